logic_unit_pipe: RTL and testbench

//   Parametrised, pipelined bitwise logic unit. It takes WIDTH-bit operands and an opcode, then

---
 rtl/logic_unit_pipe.sv | 103 ++++++++++
 tb/tb_logic_unit_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready back-pressure,
// zero/parity flags and an optional accumulate mode.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. valid is never withdrawn by this unit while it waits,
// and the payload is held stable until it is accepted. in_ready is derived only
// from registered stage valids and out_ready, so no path runs from in_valid
// to in_ready.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc_q
);

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] res;
  logic             s1_v;
  logic [WIDTH-1:0] s1_res;
  logic             s2_v;
  logic             s1_free;
  logic             s2_free;
  logic             in_xfer;

  // Ready chain: a stage is free when empty or when its contents leave this edge.
  always_comb begin
    s2_free  = !s2_v || out_ready;
    s1_free  = !s1_v || s2_free;
    in_ready = s1_free;
    in_xfer  = in_valid && s1_free;
  end

  // Stage 0: pick operand A and evaluate the selected bitwise function.
  always_comb begin
    a_eff = acc_en ? acc_q : a;
    res   = '0;
    case (op)
      3'd0:    res = a_eff & b;
      3'd1:    res = a_eff | b;
      3'd2:    res = ~a_eff;
      3'd3:    res = ~(a_eff & b);
      3'd4:    res = ~(a_eff | b);
      3'd5:    res = a_eff ^ b;
      3'd6:    res = ~(a_eff ^ b);
      default: res = b;
    endcase
  end

  // Stage 1: capture a new beat when free; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_res <= '0;
    end else if (s1_free) begin
      s1_v <= in_xfer;
      if (in_xfer) s1_res <= res;
    end
  end

  // Stage 2: take the stage 1 beat with its flags; empties when drained with nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      y      <= '0;
      zero   <= 1'b0;
      parity <= 1'b0;
    end else if (s2_free) begin
      s2_v <= s1_v;
      if (s1_v) begin
        y      <= s1_res;
        zero   <= (s1_res == '0);
        parity <= ^s1_res;
      end
    end
  end

  // Accumulator: clear dominates; otherwise follows every accepted result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (in_xfer) begin
      acc_q <= res;
    end
  end

  assign out_valid = s2_v;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH = 8).
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic         acc_en = 1'b0;
  logic         acc_clr = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         zero;
  logic         parity;
  logic [W-1:0] acc_q;

  int tests = 0;
  int fails = 0;

  logic [W+1:0] exp_q[$];   // {parity, zero, y} expected, in order
  logic [W+1:0] obs_q[$];   // {parity, zero, y} actually delivered
  logic [W-1:0] m_acc = '0;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
    .parity(parity), .acc_q(acc_q)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference function straight from the opcode table.
  function automatic logic [W-1:0] f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~x;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return x ^ z;
      3'd6: return ~(x ^ z);
      default: return z;
    endcase
  endfunction

  // Model: discard everything in flight on reset.
  always @(posedge rst) begin
    exp_q.delete();
    m_acc = '0;
  end

  // Compare process: inputs are stable from posedge+1 to the next posedge,
  // so the negedge view equals what the DUT sees at the coming edge.
  always @(negedge clk) begin
    logic [W-1:0] r;
    if (!rst) begin
      chk("acc_q", acc_q, m_acc);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("beat", {parity, zero, y}, exp_q[0]);
          if (out_ready) begin
            obs_q.push_back({parity, zero, y});
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        r = f(op, acc_en ? m_acc : a, b);
        exp_q.push_back({^r, (r == '0), r});
      end
      if (acc_clr) m_acc = '0;
      else if (in_valid && in_ready) m_acc = r;
    end
  end

  // Driver: present a beat and keep it up until accepted.
  task automatic send(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ae, input logic ac);
    logic took;
    in_valid = 1'b1; op = o; a = av; b = bv; acc_en = ae; acc_clr = ac;
    took = 1'b0;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk); took = in_ready;
      @(posedge clk); #1;
    end
    if (!took) chk("send_timeout", 1, 0);
    in_valid = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] op_exp [8];
  int acc_cnt;
  logic took;

  initial begin
    op_exp = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h3C};

    // reset defaults
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 0);
    chk("rst_parity", parity, 0);
    chk("rst_acc_q", acc_q, 0);
    @(posedge clk); #1;

    // all opcodes, single beats, latency 2
    out_ready = 1'b1;
    for (int o = 0; o < 8; o++) begin
      send(o[2:0], 8'hF0, 8'h3C, 1'b0, 1'b0);
      @(negedge clk);
      chk("lat_not_early", out_valid, 0);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      chk("op_y", y, op_exp[o]);
      @(posedge clk); #1;
    end
    drain();

    // flags
    obs_q.delete();
    send(3'd5, 8'hA5, 8'hA5, 1'b0, 1'b0);
    send(3'd7, 8'h00, 8'h07, 1'b0, 1'b0);
    drain();
    chk("flags_n", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("flags_xor", obs_q[0], {1'b0, 1'b1, 8'h00});
      chk("flags_pass", obs_q[1], {1'b1, 1'b0, 8'h07});
    end

    // back-pressure: 4 stalled cycles with a continuous stream
    obs_q.delete();
    out_ready = 1'b0;
    acc_cnt = 0;
    in_valid = 1'b1; op = 3'd7; a = '0; acc_en = 1'b0; b = 8'h11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); took = in_ready;
      @(posedge clk); #1;
      if (took) begin acc_cnt++; b = 8'h11 * (acc_cnt + 1); end
    end
    chk("bp_accepted", acc_cnt, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = acc_cnt; k < 6; k++) send(3'd7, 8'h00, 8'h11 * (k + 1), 1'b0, 1'b0);
    drain();
    chk("bp_count", obs_q.size(), 6);
    for (int k = 0; k < 6 && k < obs_q.size(); k++) chk("bp_order", obs_q[k][W-1:0], 8'h11 * (k + 1));

    // accumulate OR chain
    obs_q.delete();
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    send(3'd1, 8'hFF, 8'h01, 1'b1, 1'b0);
    send(3'd1, 8'hFF, 8'h02, 1'b1, 1'b0);
    send(3'd1, 8'hFF, 8'h04, 1'b1, 1'b0);
    send(3'd1, 8'hFF, 8'h08, 1'b1, 1'b0);
    drain();
    chk("acc_n", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("acc_y0", obs_q[0][W-1:0], 8'h01);
      chk("acc_y1", obs_q[1][W-1:0], 8'h03);
      chk("acc_y2", obs_q[2][W-1:0], 8'h07);
      chk("acc_y3", obs_q[3][W-1:0], 8'h0F);
    end
    chk("acc_final", acc_q, 8'h0F);

    // clear colliding with a transfer
    obs_q.delete();
    send(3'd0, 8'h00, 8'hFF, 1'b1, 1'b1);
    chk("clr_acc_q", acc_q, 8'h00);
    drain();
    chk("clr_n", obs_q.size(), 1);
    if (obs_q.size() == 1) chk("clr_y", obs_q[0][W-1:0], 8'h0F);

    // reset with two beats in flight
    out_ready = 1'b0;
    send(3'd7, 8'h00, 8'h5A, 1'b0, 1'b0);
    send(3'd7, 8'h00, 8'hA5, 1'b0, 1'b0);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_acc_q", acc_q, 0);
    chk("async_y", y, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    obs_q.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale", obs_q.size(), 0);
    chk("post_rst_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // absolute time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
